// File: rtl/wb_initiator_if.sv
//------------------------------------------------------------------------------
// Module      : wb_initiator_if
// Description : Command/response handshake plus pipelined Wishbone bus bundle.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface wb_initiator_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [3:0]            cmd_sel_i;
  logic [31:0]           cmd_dat_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_dat_o;
  logic [1:0]            rsp_status_o;

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic [31:0]           wb_dat_o;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;
  logic [31:0]           wb_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  rsp_ready_i,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    output rsp_ready_i,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );
endinterface

`default_nettype wire

// File: rtl/wb_initiator.sv
//------------------------------------------------------------------------------
// Module      : wb_initiator
// Description : Single-outstanding pipelined Wishbone initiator with retry
//               and timeout handling; all outputs registered.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  wb_initiator_if.master    bus
);

  localparam int c_TMO_W = $clog2(TIMEOUT + 1);
  localparam int c_RTY_W = $clog2(MAX_RETRY + 2);

  localparam logic [1:0] c_ST_OK      = 2'b00;
  localparam logic [1:0] c_ST_ERR     = 2'b01;
  localparam logic [1:0] c_ST_TIMEOUT = 2'b10;
  localparam logic [1:0] c_ST_RTY_EXH = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_BACKOFF = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [3:0]            r_sel;
  logic [31:0]           r_dat;

  logic [c_TMO_W-1:0]    r_tmo_cnt;
  logic [c_TMO_W-1:0]    w_tmo_cnt;
  logic [c_RTY_W-1:0]    r_rty_cnt;
  logic [c_RTY_W-1:0]    w_rty_cnt;

  logic [31:0]           r_rsp_dat;
  logic [31:0]           w_rsp_dat;
  logic [1:0]            r_rsp_status;
  logic [1:0]            w_rsp_status;

  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic                  r_cyc;
  logic                  r_stb;

  logic                  w_accept;
  logic                  w_tmo_hit;

  // cmd_ready_o is low for the first cycle after reset, so gating on it keeps
  // a command from being taken before the handshake is actually offered.
  assign w_accept  = bus.cmd_valid_i & r_cmd_ready;
  assign w_tmo_hit = (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));

  always_comb begin
    w_next       = r_state;
    w_tmo_cnt    = r_tmo_cnt;
    w_rty_cnt    = r_rty_cnt;
    w_rsp_dat    = r_rsp_dat;
    w_rsp_status = r_rsp_status;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next    = S_REQ;
          w_tmo_cnt = '0;
          w_rty_cnt = '0;
        end
      end

      S_REQ, S_WAIT: begin
        w_tmo_cnt = r_tmo_cnt + c_TMO_W'(1);
        // err > rty > ack; any termination beats a coincident timeout
        if (bus.wb_err_i) begin
          w_next       = S_RESP;
          w_rsp_status = c_ST_ERR;
          w_rsp_dat    = '0;
        end else if (bus.wb_rty_i) begin
          if (r_rty_cnt == c_RTY_W'(MAX_RETRY)) begin
            w_next       = S_RESP;
            w_rsp_status = c_ST_RTY_EXH;
            w_rsp_dat    = '0;
          end else begin
            w_next    = S_BACKOFF;
            w_rty_cnt = r_rty_cnt + c_RTY_W'(1);
            w_tmo_cnt = '0;
          end
        end else if (bus.wb_ack_i) begin
          w_next       = S_RESP;
          w_rsp_status = c_ST_OK;
          w_rsp_dat    = r_we ? 32'd0 : bus.wb_dat_i;
        end else if (w_tmo_hit) begin
          w_next       = S_RESP;
          w_rsp_status = c_ST_TIMEOUT;
          w_rsp_dat    = '0;
        end else if ((r_state == S_REQ) && !bus.wb_stall_i) begin
          w_next = S_WAIT;
        end
      end

      S_BACKOFF: begin
        w_next = S_REQ;
      end

      S_RESP: begin
        if (bus.rsp_ready_i) begin
          w_next = S_IDLE;
        end
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_sel        <= '0;
      r_dat        <= '0;
      r_tmo_cnt    <= '0;
      r_rty_cnt    <= '0;
      r_rsp_dat    <= '0;
      r_rsp_status <= '0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_tmo_cnt    <= w_tmo_cnt;
      r_rty_cnt    <= w_rty_cnt;
      r_rsp_dat    <= w_rsp_dat;
      r_rsp_status <= w_rsp_status;
      if (r_state == S_IDLE && w_accept) begin
        r_we  <= bus.cmd_we_i;
        r_adr <= bus.cmd_adr_i;
        r_sel <= bus.cmd_sel_i;
        r_dat <= bus.cmd_dat_i;
      end
      // Outputs decoded from the next state so they are registered yet
      // aligned with the state they describe.
      r_cmd_ready <= (w_next == S_IDLE);
      r_rsp_valid <= (w_next == S_RESP);
      r_cyc       <= (w_next == S_REQ) || (w_next == S_WAIT);
      r_stb       <= (w_next == S_REQ);
    end
  end

  assign bus.cmd_ready_o  = r_cmd_ready;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_dat_o    = r_rsp_dat;
  assign bus.rsp_status_o = r_rsp_status;
  assign bus.wb_cyc_o     = r_cyc;
  assign bus.wb_stb_o     = r_stb;
  assign bus.wb_we_o      = r_we;
  assign bus.wb_adr_o     = r_adr;
  assign bus.wb_sel_o     = r_sel;
  assign bus.wb_dat_o     = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_wb_initiator.sv
//------------------------------------------------------------------------------
// Module      : tb_wb_initiator
// Description : Directed self-checking bench for wb_initiator.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_initiator;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  wb_initiator_if #(.ADDR_WIDTH(32)) bus ();

  wb_initiator #(
    .ADDR_WIDTH (32),
    .TIMEOUT    (8),
    .MAX_RETRY  (3)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
    chk("cmd_ready_before_issue", 64'(bus.cmd_ready_o), 64'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_sel_i   = sel;
    bus.cmd_dat_i   = dat;
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_adr_i   = 32'hFFFF_FFFF;
    bus.cmd_dat_i   = 32'h0;
  endtask

  task automatic drain();
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("rsp_valid_after_drain", 64'(bus.rsp_valid_o), 64'd0);
    chk("cmd_ready_after_drain", 64'(bus.cmd_ready_o), 64'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wb_ack_i    = 1'b0;
    bus.wb_err_i    = 1'b0;
    bus.wb_rty_i    = 1'b0;
    bus.wb_stall_i  = 1'b0;
    bus.wb_dat_i    = '0;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    chk("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_adr", 64'(bus.wb_adr_o), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("first_edge_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);

    // Read of 0x4, ack one cycle after strobe
    issue(1'b0, 32'h4, 4'hF, 32'h0);
    chk("rd_c1_cyc", 64'(bus.wb_cyc_o), 64'd1);
    chk("rd_c1_stb", 64'(bus.wb_stb_o), 64'd1);
    chk("rd_c1_adr", 64'(bus.wb_adr_o), 64'h4);
    chk("rd_c1_we", 64'(bus.wb_we_o), 64'd0);
    chk("rd_c1_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    tick();
    chk("rd_c2_stb", 64'(bus.wb_stb_o), 64'd0);
    chk("rd_c2_cyc", 64'(bus.wb_cyc_o), 64'd1);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hDEAD_BEEF;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 32'h1111_1111;
    chk("rd_c3_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("rd_c3_rsp_dat", 64'(bus.rsp_dat_o), 64'hDEAD_BEEF);
    chk("rd_c3_status", 64'(bus.rsp_status_o), 64'd0);
    chk("rd_c3_cyc", 64'(bus.wb_cyc_o), 64'd0);
    chk("rd_c3_stb", 64'(bus.wb_stb_o), 64'd0);
    drain();

    // Write with stall for three cycles
    bus.wb_stall_i = 1'b1;
    issue(1'b1, 32'h100, 4'h3, 32'hA5A5_1234);
    for (int i = 0; i < 4; i++) begin
      chk("wr_stall_stb", 64'(bus.wb_stb_o), 64'd1);
      chk("wr_stall_adr", 64'(bus.wb_adr_o), 64'h100);
      chk("wr_stall_dat", 64'(bus.wb_dat_o), 64'hA5A5_1234);
      chk("wr_stall_sel", 64'(bus.wb_sel_o), 64'h3);
      chk("wr_stall_we", 64'(bus.wb_we_o), 64'd1);
      if (i == 3) bus.wb_stall_i = 1'b0;
      tick();
    end
    chk("wr_wait_stb", 64'(bus.wb_stb_o), 64'd0);
    chk("wr_wait_cyc", 64'(bus.wb_cyc_o), 64'd1);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h7777_7777;
    tick();
    bus.wb_ack_i = 1'b0;
    chk("wr_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("wr_rsp_dat", 64'(bus.rsp_dat_o), 64'd0);
    chk("wr_status", 64'(bus.rsp_status_o), 64'd0);
    drain();

    // Retry four times: three re-issues, then exhausted
    issue(1'b0, 32'h20, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("rty_req_stb", 64'(bus.wb_stb_o), 64'd1);
      chk("rty_req_adr", 64'(bus.wb_adr_o), 64'h20);
      tick();
      chk("rty_wait_cyc", 64'(bus.wb_cyc_o), 64'd1);
      bus.wb_rty_i = 1'b1;
      tick();
      bus.wb_rty_i = 1'b0;
      if (k < 3) begin
        chk("rty_backoff_cyc", 64'(bus.wb_cyc_o), 64'd0);
        chk("rty_backoff_stb", 64'(bus.wb_stb_o), 64'd0);
        chk("rty_backoff_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        if (k == 1) bus.wb_ack_i = 1'b1;
        tick();
        bus.wb_ack_i = 1'b0;
      end else begin
        chk("rty_exh_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        chk("rty_exh_status", 64'(bus.rsp_status_o), 64'd3);
        chk("rty_exh_cyc", 64'(bus.wb_cyc_o), 64'd0);
      end
    end
    drain();

    // Timeout after 8 bus cycles, late ack ignored
    issue(1'b0, 32'h40, 4'hF, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      chk("tmo_cyc_high", 64'(bus.wb_cyc_o), 64'd1);
      chk("tmo_rsp_valid_low", 64'(bus.rsp_valid_o), 64'd0);
      tick();
    end
    chk("tmo_cyc_drop", 64'(bus.wb_cyc_o), 64'd0);
    chk("tmo_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("tmo_status", 64'(bus.rsp_status_o), 64'd2);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h5555_AAAA;
    tick();
    bus.wb_ack_i = 1'b0;
    chk("tmo_late_ack_status", 64'(bus.rsp_status_o), 64'd2);
    chk("tmo_late_ack_dat", 64'(bus.rsp_dat_o), 64'd0);
    chk("tmo_late_ack_cyc", 64'(bus.wb_cyc_o), 64'd0);
    drain();

    // ack + err together, response held under back-pressure
    issue(1'b0, 32'h80, 4'hF, 32'h0);
    tick();
    bus.wb_ack_i = 1'b1;
    bus.wb_err_i = 1'b1;
    bus.wb_dat_i = 32'h1234_5678;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    for (int h = 0; h < 5; h++) begin
      bus.wb_dat_i = 32'h9000_0000 + 32'(h);
      chk("err_hold_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("err_hold_status", 64'(bus.rsp_status_o), 64'd1);
      chk("err_hold_dat", 64'(bus.rsp_dat_o), 64'd0);
      chk("err_hold_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
      tick();
    end
    drain();

    // rty beats ack in REQ even while stalled; re-issue then ack in REQ
    bus.wb_stall_i = 1'b1;
    bus.wb_rty_i   = 1'b1;
    bus.wb_ack_i   = 1'b1;
    issue(1'b0, 32'hC0, 4'hF, 32'h0);
    tick();
    bus.wb_stall_i = 1'b0;
    bus.wb_rty_i   = 1'b0;
    bus.wb_ack_i   = 1'b0;
    chk("prio_backoff_cyc", 64'(bus.wb_cyc_o), 64'd0);
    chk("prio_backoff_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    tick();
    chk("prio_reissue_stb", 64'(bus.wb_stb_o), 64'd1);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hCAFE_F00D;
    tick();
    bus.wb_ack_i = 1'b0;
    chk("prio_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("prio_rsp_dat", 64'(bus.rsp_dat_o), 64'hCAFE_F00D);
    chk("prio_status", 64'(bus.rsp_status_o), 64'd0);
    chk("prio_stb_after_term", 64'(bus.wb_stb_o), 64'd0);
    drain();

    // Asynchronous reset during WAIT, then a clean transaction
    issue(1'b0, 32'h10, 4'hF, 32'h0);
    tick();
    chk("arst_wait_cyc", 64'(bus.wb_cyc_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    chk("arst_stb", 64'(bus.wb_stb_o), 64'd0);
    chk("arst_adr", 64'(bus.wb_adr_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_release_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    issue(1'b0, 32'h8, 4'hF, 32'h0);
    chk("arst_new_stb", 64'(bus.wb_stb_o), 64'd1);
    chk("arst_new_adr", 64'(bus.wb_adr_o), 64'h8);
    tick();
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h0BAD_F00D;
    tick();
    bus.wb_ack_i = 1'b0;
    chk("arst_new_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("arst_new_rsp_dat", 64'(bus.rsp_dat_o), 64'h0BAD_F00D);
    chk("arst_new_status", 64'(bus.rsp_status_o), 64'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
